// File: rtl/freq_stream_pkg.sv
// rtl/freq_stream_pkg.sv - shared widths, FSM states and header layout for the tone stream unpacker
package freq_stream_pkg;

  localparam int DATA_W = 80;
  localparam int IDX_W  = 7;
  localparam int K_W    = 14;
  localparam int OUT_W  = 32;

  localparam int HDR_LAST    = 31;
  localparam int HDR_ERR     = 30;
  localparam int HDR_IDX_LSB = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_D0,
    ST_D1,
    ST_D2
  } state_e;

  // Header beat: tlast and error flags on top, index above k, zeros between.
  function automatic logic [OUT_W-1:0] make_hdr(
    input logic             last,
    input logic             err,
    input logic [IDX_W-1:0] idx,
    input logic [K_W-1:0]   k
  );
    logic [OUT_W-1:0] h;
    h                        = '0;
    h[HDR_LAST]              = last;
    h[HDR_ERR]               = err;
    h[HDR_IDX_LSB +: IDX_W]  = idx;
    h[K_W-1:0]               = k;
    return h;
  endfunction

endpackage

// File: rtl/stream_seq_check.sv
// rtl/stream_seq_check.sv - per-frame index/k sequence checker for incoming tone samples
module stream_seq_check
  import freq_stream_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [K_W-1:0]   k_i,
  input  logic             last_i,
  output logic             err_o
);

  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic [K_W-1:0]   frame_k_q, frame_k_d;
  logic             first_q, first_d;

  // Compare the accepted sample against expectations; always resync to what arrived
  always_comb begin
    exp_idx_d = exp_idx_q;
    frame_k_d = frame_k_q;
    first_d   = first_q;
    err_o     = 1'b0;
    if (hs_i) begin
      err_o     = (idx_i != exp_idx_q) || (!first_q && (k_i != frame_k_q));
      // Index wraps 127 -> 0 naturally in IDX_W bits.
      exp_idx_d = last_i ? '0 : idx_i + 7'd1;
      // Tracking the received k keeps the frame value and resyncs after a k error.
      frame_k_d = k_i;
      first_d   = last_i;
    end
  end

  // Sequence tracking state; reset means the next sample starts a fresh frame at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_idx_q <= '0;
      frame_k_q <= '0;
      first_q   <= 1'b1;
    end else begin
      exp_idx_q <= exp_idx_d;
      frame_k_q <= frame_k_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: rtl/freq_stream_unpacker.sv
// rtl/freq_stream_unpacker.sv - serializes 80-bit tone samples into header plus three 32-bit beats
module freq_stream_unpacker
  import freq_stream_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   dev_clk,
  input  logic                   dev_rst,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic [IDX_W+K_W-1:0]   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic                   err_clr,
  output logic                   err_seq,
  output logic [CNT_W-1:0]       frame_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [K_W-1:0]    k_q;
  logic              last_q;
  logic              err_q;
  logic              err_seq_q;
  logic [CNT_W-1:0]  frame_count_q;

  logic              s_hs;
  logic              m_hs;
  logic              smp_err;

  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;

  stream_seq_check u_seq_check (
    .clk    (dev_clk),
    .rst_n  (dev_rst),
    .hs_i   (s_hs),
    .idx_i  (s_axis_tuser[IDX_W+K_W-1:K_W]),
    .k_i    (s_axis_tuser[K_W-1:0]),
    .last_i (s_axis_tlast),
    .err_o  (smp_err)
  );

  // Next state and beat outputs; outputs depend only on registered state except the D2 ready path
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (state_q)
      ST_IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = ST_HDR;
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = make_hdr(last_q, err_q, idx_q, k_q);
        if (m_axis_tready) state_d = ST_D0;
      end
      ST_D0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = data_q[31:0];
        if (m_axis_tready) state_d = ST_D1;
      end
      ST_D1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = data_q[63:32];
        if (m_axis_tready) state_d = ST_D2;
      end
      ST_D2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_q;
        m_axis_tdata  = {16'h0000, data_q[79:64]};
        // Accepting the next sample while the last beat leaves avoids a bubble.
        s_axis_tready = m_axis_tready;
        if (m_axis_tready) state_d = s_axis_tvalid ? ST_HDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register; reset drops tvalid at once and abandons any partial sample
  always_ff @(posedge dev_clk or negedge dev_rst) begin
    if (!dev_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Sample register captures data, sideband, tlast and the sequence verdict on every input handshake
  always_ff @(posedge dev_clk or negedge dev_rst) begin
    if (!dev_rst) begin
      data_q <= '0;
      idx_q  <= '0;
      k_q    <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (s_hs) begin
      data_q <= s_axis_tdata;
      idx_q  <= s_axis_tuser[IDX_W+K_W-1:K_W];
      k_q    <= s_axis_tuser[K_W-1:0];
      last_q <= s_axis_tlast;
      err_q  <= smp_err;
    end
  end

  // Sticky error for software; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge dev_clk or negedge dev_rst) begin
    if (!dev_rst)             err_seq_q <= 1'b0;
    else if (s_hs && smp_err) err_seq_q <= 1'b1;
    else if (err_clr)         err_seq_q <= 1'b0;
  end

  // Count frames as their final beat leaves; wraps at full scale
  always_ff @(posedge dev_clk or negedge dev_rst) begin
    if (!dev_rst)                               frame_count_q <= '0;
    else if (m_hs && state_q == ST_D2 && last_q) frame_count_q <= frame_count_q + 1'b1;
  end

  assign err_seq     = err_seq_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/freq_stream_unpacker.md
# freq_stream_unpacker

Receiving end of the freq_selector tone stream. It accepts 80-bit tone samples with `{index, k}` sideband and frame `tlast`, and checks index/k sequencing per frame. It serializes each sample into four 32-bit AXI-stream beats (header plus three data words) for the PS-side DMA. It also maintains a frame counter and a sticky sequence-error flag for software.

## Interface
Parameters:
- `CNT_W`, 16: width of `frame_count`.

Ports:
- `dev_clk` in 1: single clock for all logic.
- `dev_rst` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in 80: tone sample (I/Q data from the selector).
- `s_axis_tuser` in 21: `{index[6:0], k[13:0]}`.
- `s_axis_tvalid` in 1: sample valid.
- `s_axis_tready` out 1: sample accepted when high with `tvalid`.
- `s_axis_tlast` in 1: last sample of frame.
- `m_axis_tdata` out 32: serialized beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last beat of frame.
- `err_clr` in 1: one-cycle pulse, clears `err_seq`.
- `err_seq` out 1: sticky sequence error.
- `frame_count` out CNT_W: completed frames emitted, wraps.

## Operation
- FSM states: IDLE, HDR, D0, D1, D2. The sample register is loaded on every input handshake.
- IDLE: `s_axis_tready`=1. On handshake, latch data, tuser, tlast and the per-sample error flag, then go to HDR.
- HDR beat: [31]=latched tlast, [30]=sample error, [29:21]=0, [20:14]=index, [13:0]=k.
- D0 beat = data[31:0]. D1 beat = data[63:32]. D2 beat = {16'h0000, data[79:64]}.
- Each state advances only on `m_axis_tvalid && m_axis_tready`.
- `m_axis_tlast` is 1 only on the D2 beat of a sample latched with tlast=1.
- `s_axis_tready` = (state==IDLE) || (state==D2 && `m_axis_tready`).
- Leaving D2:
  - With a new input handshake in the same cycle: go to HDR with the new sample.
  - Otherwise: go to IDLE.
- Sequence check, evaluated at input handshake:
  - `exp_idx` (7 bit) is reset to 0, and set to 0 after a tlast sample; otherwise it becomes received index+1, mod 128 (127→0 is legal).
  - `frame_k` is captured from the first sample of each frame.
  - The error flag is set if index≠`exp_idx`, or if k≠`frame_k` on a non-first sample.
  - Resync is to the received values. No sample is ever dropped.
- `err_seq`: set by any sample error and cleared by `err_clr`. If both happen in the same cycle, set wins.
- `frame_count` increments on the D2 handshake carrying tlast, and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: state=IDLE, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `s_axis_tready`=1 after reset release, `err_seq`=0, `frame_count`=0, `exp_idx`=0.
- Latency: input handshake at cycle N puts the HDR beat valid at N+1 (registered output).
- Throughput: with `m_axis_tready` held high, one sample per 4 cycles and no bubbles between samples.
- Output stability: `m_axis_tdata`/`tvalid`/`tlast` hold stable while `tvalid`=1 and `tready`=0. `tvalid` never drops without a handshake.
- `s_axis_tready` depends combinationally on `m_axis_tready` only in D2. No other input-to-output combinational path exists.
- Reset mid-sample: the partial sample is discarded and `m_axis_tvalid` drops immediately, asynchronously. The next frame expects index 0.
- `err_seq` updates the cycle after the offending handshake. `frame_count` updates the cycle after the D2 handshake.

## Structure
- Package `freq_stream_pkg`:
  - widths: DATA_W=80, IDX_W=7, K_W=14, OUT_W=32;
  - FSM state enum;
  - header bit positions HDR_LAST=31, HDR_ERR=30, HDR_IDX_LSB=14.
- Sub-module `stream_seq_check`: holds `exp_idx`/`frame_k`/first-of-frame tracking. Inputs are handshake, index, k and tlast; output is the per-sample error flag. The top level holds the FSM, sample register, `err_seq` and `frame_count`.

## Test plan
- Single sample, data=80'h1234_89ABCDEF_01234567, index=0, k=5, tlast=1, `m_axis_tready`=1:
  - beats 0x8000_0005, 0x0123_4567, 0x89AB_CDEF, 0x0000_1234;
  - tlast on beat 4; `frame_count`=1; `err_seq`=0.
- Frame of 128 samples (index 0..127, k=3) back-to-back with `m_axis_tready`=1:
  - 512 beats with no idle cycles; tlast only on beat 512; no errors; `frame_count`=1.
- Index jump 0,1,3 within a frame:
  - third header has bit30=1; `err_seq`=1;
  - the next sample with index 4 is clean; `err_clr` returns `err_seq` to 0.
- k change mid-frame (k=3 then k=4, index consecutive):
  - flag set on the second sample;
  - the next frame starting at index 0 with k=4 is clean.
- Random `m_axis_tready` (50%) over 10 frames:
  - all beats match the model; output is stable under stall; `s_axis_tready` low except in IDLE/D2 with ready.
- Assert reset during D1, then send index=0: no stray beats, the next header is correct, no error raised; also `frame_count` wraps 0xFFFF→0 via a forced preload.
